decode_pipe: RTL and testbench
==============================

# decode_pipe

Registered, handshaked instruction decode stage; next generation of the team's combinational RV32I control decoder. Sits between the if_id register and id_ex: accepts a fetched instruction over a valid/ready handshake, decodes it into the control bundle plus M-extension, illegal-instruction and flush support, and presents the result one cycle later through a two-entry skid buffer. Lets the front end stall and flush without the combinational ready path crossing the decode logic.

## Interface
- `XLEN`, 32: instruction and bus width; only 32 is legal.
- `M_EXT`, 1: 1 decodes RV32M (func7 = 0x01 on OP opcode); 0 flags it illegal.
- `SKID`, 1: 1 gives a two-entry skid buffer; 0 gives a single register with `in_ready` = `~out_valid | out_ready`.
- `clk` in 1: single clock. Reset is synchronous and active-low.
- `rst_n` in 1: synchronous, active-low reset.
- `flush` in 1: discard all held entries; has priority over everything except reset.
- `in_valid` in 1: instruction valid from if_id.
- `in_ready` out 1: stage can accept.
- `in_inst` in XLEN: raw instruction.
- `in_pc` in XLEN: instruction PC; passed through unchanged.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: id_ex accepts.
- `out_pc` out XLEN / `out_inst` out XLEN: passthrough of the PC and raw instruction.
- `imm_ctrl` out 3: 0 none, 1 I, 2 S, 3 U, 4 B, 5 J.
- `rmem`, `wmem`, `wen`, `jmp`, `jcc`, `jal`, `jalr`, `lui`, `auipc`, `inst_R` out 1 each: decoded control strobes.
- `alu_ctrl` out 3: func3, forced to 0 for LUI, AUIPC, JAL, JALR, LOAD and STORE.
- `sub` out 1: func7[5] on OP opcode only, otherwise 0.
- `sign` out 1: func7[5].
- `mem_type` out 2: func3[1:0].
- `mem_sign` out 1: func3[2].
- `muldiv` out 1: OP opcode with func7 = 0x01 and `M_EXT` = 1.
- `illegal` out 1: instruction is not decodable.

## Operation
- Opcode decode matches the existing RV32I control map: I-type ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP.
- `wen` is asserted for OP-IMM, OP, LOAD, JAL, JALR, LUI and AUIPC.
- `illegal` is asserted for any of the following:
  - `inst[1:0]` != 2'b11;
  - opcode outside the decoded set, FENCE (0001111) or SYSTEM (1110011);
  - OP opcode with func7 not in {0x00, 0x20, plus 0x01 when `M_EXT`};
  - func7 = 0x20 on OP with func3 not 0 or 5.
- When `illegal` is 1, all of `wen`, `rmem`, `wmem`, `jmp`, `jcc` and `muldiv` are forced to 0. `imm_ctrl` is then 0 and `alu_ctrl` is 0.
- Decode is combinational on `in_inst`. The result is captured together with `in_pc` and `in_inst` as one entry.
- Storage (`SKID` = 1) is a main register M (drives the outputs) and a skid register S. State is {EMPTY, ONE (M full), TWO (M and S full)}.
- `in_ready` = (state != TWO), registered.
- Input fire = `in_valid` & `in_ready`. Output fire = `out_valid` & `out_ready`.
- State transitions:
  - EMPTY + in fire -> ONE; M <= input.
  - ONE + in fire + out fire -> ONE; M <= input.
  - ONE + in fire, no out fire -> TWO; S <= input.
  - ONE + out fire, no in -> EMPTY.
  - TWO + out fire -> ONE; M <= S. No input is accepted in TWO.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by `flush`.
- Flush: the next state is EMPTY and any input presented in the same cycle is dropped. `in_ready` returns to 1 in the cycle after the flush.
- Reset (`rst_n` = 0 at a clock edge), including mid-operation: state EMPTY, all entries cleared, every output 0.

## Timing
- Latency is 1 cycle: an input accepted at edge N drives `out_valid` from edge N onward, i.e. it is visible in cycle N+1.
- Throughput is 1 instruction/cycle while `out_ready` = 1.
- Outputs change only on `clk` edges and never combinationally with `in_*` or `out_ready`. Exception: when `SKID` = 0, `in_ready` depends combinationally on `out_ready`.
- Bundle outputs are held stable while `out_valid` & ~`out_ready`.
- Reset values: `in_ready` = 0 while `rst_n` = 0 and 1 from the first cycle after release. All other outputs are 0.

## Test plan
- ADDI x1,x0,5 (0x00500093), `out_ready` = 1: next cycle `out_valid` = 1, `imm_ctrl` = 1, `wen` = 1, `alu_ctrl` = 0, `illegal` = 0, `out_pc` = `in_pc`.
- Back-to-back ADD (0x002081B3) then SUB (0x402081B3): `sub` = 0 then 1, `inst_R` = 1 for both; then SW (0x0020A023): `imm_ctrl` = 2, `wmem` = 1, `wen` = 0, `alu_ctrl` = 0.
- MUL (0x02208033): with `M_EXT` = 1, `muldiv` = 1 and `illegal` = 0; with `M_EXT` = 0, `illegal` = 1 and `wen` = 0. Inputs 0x00000000 and 0x00000073 give `illegal` = 1.
- Backpressure: `out_ready` = 0 while 3 instructions are offered: first two accepted, `in_ready` = 0 on the third. Releasing `out_ready` delivers them in order, with no loss or duplication.
- Flush while in TWO with `in_valid` = 1: next cycle `out_valid` = 0 and `in_ready` = 1, and the flushed-cycle input never appears at the output.
- `rst_n` pulled low in TWO for one cycle: all outputs 0, then normal operation resumes from EMPTY.

Source files
------------

// File: rtl/decode_pipe_if.sv
`default_nettype none
// ============================================================================
// decode_pipe_if : handshake + decoded-bundle bus around the decode stage
// Revision: 1.0
// ============================================================================
interface decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic [2:0]      imm_ctrl;
    logic            rmem, wmem, wen, jmp, jcc, jal, jalr, lui, auipc, inst_R;
    logic [2:0]      alu_ctrl;
    logic            sub, sign;
    logic [1:0]      mem_type;
    logic            mem_sign, muldiv, illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, imm_ctrl, rmem, wmem, wen,
               jmp, jcc, jal, jalr, lui, auipc, inst_R, alu_ctrl, sub, sign,
               mem_type, mem_sign, muldiv, illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_inst, imm_ctrl, rmem, wmem, wen,
               jmp, jcc, jal, jalr, lui, auipc, inst_R, alu_ctrl, sub, sign,
               mem_type, mem_sign, muldiv, illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// decode_pipe : registered RV32I(+M) decode stage with valid/ready skid buffer
// Revision: 1.0
// ============================================================================
module decode_pipe #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1,
    parameter int SKID  = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     flush,
    decode_pipe_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [2:0]      imm_ctrl;
        logic            rmem, wmem, wen, jmp, jcc, jal, jalr, lui, auipc, inst_R;
        logic [2:0]      alu_ctrl;
        logic            sub, sign;
        logic [1:0]      mem_type;
        logic            mem_sign, muldiv, illegal;
    } entry_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_op;
    logic f7_ok, illegal_w;
    entry_t dec_d;

    assign opc = bus.in_inst[6:0];
    assign f3  = bus.in_inst[14:12];
    assign f7  = bus.in_inst[31:25];

    // Opcode compares include bits [1:0], so a non-32-bit encoding matches nothing
    assign is_opimm  = (opc == 7'b0010011);
    assign is_load   = (opc == 7'b0000011);
    assign is_store  = (opc == 7'b0100011);
    assign is_branch = (opc == 7'b1100011);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_op     = (opc == 7'b0110011);

    assign f7_ok = (f7 == 7'h00)
                 | ((f7 == 7'h20) & ((f3 == 3'd0) | (f3 == 3'd5)))
                 | ((f7 == 7'h01) & (M_EXT != 0));

    assign illegal_w = ~(is_opimm | is_load | is_store | is_branch | is_jal | is_jalr
                         | is_lui | is_auipc | is_op) | (is_op & ~f7_ok);

    always_comb begin
        dec_d          = '0;
        dec_d.pc       = bus.in_pc;
        dec_d.inst     = bus.in_inst;
        dec_d.jal      = is_jal;
        dec_d.jalr     = is_jalr;
        dec_d.lui      = is_lui;
        dec_d.auipc    = is_auipc;
        dec_d.inst_R   = is_op;
        dec_d.sub      = is_op & f7[5];
        dec_d.sign     = f7[5];
        dec_d.mem_type = f3[1:0];
        dec_d.mem_sign = f3[2];
        dec_d.illegal  = illegal_w;
        if (!illegal_w) begin
            dec_d.imm_ctrl = (is_opimm | is_load | is_jalr) ? 3'd1 :
                             is_store                       ? 3'd2 :
                             (is_lui | is_auipc)            ? 3'd3 :
                             is_branch                      ? 3'd4 :
                             is_jal                         ? 3'd5 : 3'd0;
            dec_d.rmem     = is_load;
            dec_d.wmem     = is_store;
            dec_d.wen      = is_opimm | is_op | is_load | is_jal | is_jalr | is_lui | is_auipc;
            dec_d.jmp      = is_jal | is_jalr;
            dec_d.jcc      = is_branch;
            dec_d.alu_ctrl = (is_opimm | is_op | is_branch) ? f3 : 3'd0;
            dec_d.muldiv   = is_op & (f7 == 7'h01) & (M_EXT != 0);
        end
    end

    entry_t out_w;
    logic   out_valid_w;
    logic   in_ready_w;

    if (SKID != 0) begin : g_skid
        typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_TWO   = 2'd2
        } state_t;

        state_t state_q;
        entry_t m_q, s_q;
        logic   valid_q, ready_q;
        logic   in_fire, out_fire;

        assign in_fire  = bus.in_valid & ready_q;
        assign out_fire = valid_q & bus.out_ready;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= ST_EMPTY;
                m_q     <= '0;
                s_q     <= '0;
                valid_q <= 1'b0;
                ready_q <= 1'b0;
            end else if (flush) begin
                state_q <= ST_EMPTY;
                m_q     <= '0;
                s_q     <= '0;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        ready_q <= 1'b1;
                        if (in_fire) begin
                            m_q     <= dec_d;
                            valid_q <= 1'b1;
                            state_q <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && out_fire) begin
                            m_q <= dec_d;
                        end else if (in_fire) begin
                            s_q     <= dec_d;
                            ready_q <= 1'b0;
                            state_q <= ST_TWO;
                        end else if (out_fire) begin
                            m_q     <= '0;
                            valid_q <= 1'b0;
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (out_fire) begin
                            m_q     <= s_q;
                            s_q     <= '0;
                            ready_q <= 1'b1;
                            state_q <= ST_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end

        assign out_w       = m_q;
        assign out_valid_w = valid_q;
        assign in_ready_w  = ready_q;
    end else begin : g_single
        entry_t m_q;
        logic   valid_q, en_q;
        logic   in_fire, out_fire;

        // en_q keeps in_ready low while reset is held
        assign in_ready_w = en_q & (~valid_q | bus.out_ready);
        assign in_fire    = bus.in_valid & in_ready_w;
        assign out_fire   = valid_q & bus.out_ready;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                m_q     <= '0;
                valid_q <= 1'b0;
                en_q    <= 1'b0;
            end else if (flush) begin
                m_q     <= '0;
                valid_q <= 1'b0;
                en_q    <= 1'b1;
            end else begin
                en_q <= 1'b1;
                if (in_fire) begin
                    m_q     <= dec_d;
                    valid_q <= 1'b1;
                end else if (out_fire) begin
                    m_q     <= '0;
                    valid_q <= 1'b0;
                end
            end
        end

        assign out_w       = m_q;
        assign out_valid_w = valid_q;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_pc    = out_w.pc;
    assign bus.out_inst  = out_w.inst;
    assign bus.imm_ctrl  = out_w.imm_ctrl;
    assign bus.rmem      = out_w.rmem;
    assign bus.wmem      = out_w.wmem;
    assign bus.wen       = out_w.wen;
    assign bus.jmp       = out_w.jmp;
    assign bus.jcc       = out_w.jcc;
    assign bus.jal       = out_w.jal;
    assign bus.jalr      = out_w.jalr;
    assign bus.lui       = out_w.lui;
    assign bus.auipc     = out_w.auipc;
    assign bus.inst_R    = out_w.inst_R;
    assign bus.alu_ctrl  = out_w.alu_ctrl;
    assign bus.sub       = out_w.sub;
    assign bus.sign      = out_w.sign;
    assign bus.mem_type  = out_w.mem_type;
    assign bus.mem_sign  = out_w.mem_sign;
    assign bus.muldiv    = out_w.muldiv;
    assign bus.illegal   = out_w.illegal;
endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_pipe : scoreboard bench for two decode_pipe builds sharing stimulus
//                  (skid + RV32M, and single-register without RV32M)
// Revision: 1.0
// ============================================================================
module tb_decode_pipe;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  imm_ctrl;
        logic        rmem, wmem, wen, jmp, jcc, jal, jalr, lui, auipc, inst_R;
        logic [2:0]  alu_ctrl;
        logic        sub, sign;
        logic [1:0]  mem_type;
        logic        mem_sign, muldiv, illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_pipe_if #(.XLEN(32)) bus1 ();
    decode_pipe_if #(.XLEN(32)) bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_inst   = in_inst;
    assign bus1.in_pc     = in_pc;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_inst   = in_inst;
    assign bus0.in_pc     = in_pc;
    assign bus0.out_ready = out_ready;

    decode_pipe #(.XLEN(32), .M_EXT(1), .SKID(1)) u_dut_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1.slave)
    );
    decode_pipe #(.XLEN(32), .M_EXT(0), .SKID(0)) u_dut_single (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0.slave)
    );

    exp_t got [2];
    logic got_rdy [2];
    logic got_vld [2];

    assign got[0] = {bus1.out_pc, bus1.out_inst, bus1.imm_ctrl, bus1.rmem, bus1.wmem, bus1.wen,
                     bus1.jmp, bus1.jcc, bus1.jal, bus1.jalr, bus1.lui, bus1.auipc, bus1.inst_R,
                     bus1.alu_ctrl, bus1.sub, bus1.sign, bus1.mem_type, bus1.mem_sign,
                     bus1.muldiv, bus1.illegal};
    assign got[1] = {bus0.out_pc, bus0.out_inst, bus0.imm_ctrl, bus0.rmem, bus0.wmem, bus0.wen,
                     bus0.jmp, bus0.jcc, bus0.jal, bus0.jalr, bus0.lui, bus0.auipc, bus0.inst_R,
                     bus0.alu_ctrl, bus0.sub, bus0.sign, bus0.mem_type, bus0.mem_sign,
                     bus0.muldiv, bus0.illegal};
    assign got_rdy[0] = bus1.in_ready;
    assign got_rdy[1] = bus0.in_ready;
    assign got_vld[0] = bus1.out_valid;
    assign got_vld[1] = bus0.out_valid;

    // Reference decode, written per instruction class from the ISA rules
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc, input bit mext);
        exp_t e;
        bit legal;
        logic [2:0] f3;
        logic [6:0] f7;
        e = '0;
        legal = 1'b1;
        f3 = inst[14:12];
        f7 = inst[31:25];
        case (inst[6:0])
            7'h13: begin e.imm_ctrl = 3'd1; e.wen = 1'b1; e.alu_ctrl = f3; end
            7'h03: begin e.imm_ctrl = 3'd1; e.wen = 1'b1; e.rmem = 1'b1; end
            7'h23: begin e.imm_ctrl = 3'd2; e.wmem = 1'b1; end
            7'h63: begin e.imm_ctrl = 3'd4; e.jcc = 1'b1; e.alu_ctrl = f3; end
            7'h6f: begin e.imm_ctrl = 3'd5; e.jmp = 1'b1; e.jal = 1'b1; e.wen = 1'b1; end
            7'h67: begin e.imm_ctrl = 3'd1; e.jmp = 1'b1; e.jalr = 1'b1; e.wen = 1'b1; end
            7'h37: begin e.imm_ctrl = 3'd3; e.lui = 1'b1; e.wen = 1'b1; end
            7'h17: begin e.imm_ctrl = 3'd3; e.auipc = 1'b1; e.wen = 1'b1; end
            7'h33: begin
                e.inst_R = 1'b1; e.wen = 1'b1; e.alu_ctrl = f3; e.sub = f7[5];
                if (f7 == 7'h00)                legal = 1'b1;
                else if (f7 == 7'h20)           legal = (f3 == 3'd0) || (f3 == 3'd5);
                else if (f7 == 7'h01 && mext)   e.muldiv = 1'b1;
                else                            legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.illegal = 1'b1;
            e.wen = 1'b0; e.rmem = 1'b0; e.wmem = 1'b0; e.jmp = 1'b0; e.jcc = 1'b0;
            e.muldiv = 1'b0; e.imm_ctrl = 3'd0; e.alu_ctrl = 3'd0;
        end
        e.pc = pc;
        e.inst = inst;
        e.sign = inst[30];
        e.mem_type = inst[13:12];
        e.mem_sign = inst[14];
        return e;
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] g, input logic [127:0] x);
        checks++;
        if (g !== x) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, g, x);
        end
    endtask

    // Scoreboard: expected entries held per DUT, checked on the falling edge
    exp_t q [2][$];
    bit   in_rst = 1'b1;
    bit   exp_rdy [2];
    bit   exp_vld [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (in_rst)
                exp_rdy[k] = 1'b0;
            else if (k == 0)
                exp_rdy[k] = (q[k].size() < 2);
            else
                exp_rdy[k] = (q[k].size() == 0) || out_ready;
            exp_vld[k] = !in_rst && (q[k].size() > 0);
            chk("in_ready", k, {127'd0, got_rdy[k]}, {127'd0, exp_rdy[k]});
            chk("out_valid", k, {127'd0, got_vld[k]}, {127'd0, exp_vld[k]});
            if (in_rst)
                chk("reset_bundle", k, {41'd0, got[k]}, 128'd0);
            else if (q[k].size() > 0)
                chk("bundle", k, {41'd0, got[k]}, {41'd0, q[k][0]});
        end
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
            in_rst = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    q[k].delete();
                end else begin
                    if (exp_vld[k] && out_ready) void'(q[k].pop_front());
                    if (in_valid && exp_rdy[k]) q[k].push_back(model(in_inst, in_pc, k == 0));
                end
            end
            in_rst = 1'b0;
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[6:0] = 7'h13;
            1:  r[6:0] = 7'h03;
            2:  r[6:0] = 7'h23;
            3:  r[6:0] = 7'h63;
            4:  r[6:0] = 7'h6f;
            5:  r[6:0] = 7'h67;
            6:  r[6:0] = 7'h37;
            7:  r[6:0] = 7'h17;
            8:  r[6:0] = 7'h0f;
            9:  r[6:0] = 7'h73;
            10: r[6:0] = r[6:0];
            default: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: r[31:25] = r[31:25];
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = ins;
        in_pc     = in_pc + 32'd4;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_inst = 32'd0; in_pc = 32'h0000_1000; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Basic decode set, full throughput
        cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0);
        cyc(1'b1, 32'h0020_81B3, 1'b1, 1'b0);
        cyc(1'b1, 32'h4020_81B3, 1'b1, 1'b0);
        cyc(1'b1, 32'h0020_A023, 1'b1, 1'b0);
        cyc(1'b1, 32'h0220_8033, 1'b1, 1'b0);
        cyc(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        cyc(1'b1, 32'h0000_0073, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure: third offer is refused, then drain in order
        cyc(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        cyc(1'b1, 32'h4020_81B3, 1'b0, 1'b0);
        cyc(1'b1, 32'h0020_A023, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while full with an input offered
        cyc(1'b1, 32'h0020_81B3, 1'b0, 1'b0);
        cyc(1'b1, 32'h0220_8033, 1'b0, 1'b0);
        cyc(1'b1, 32'h0050_0093, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0020_A023, 1'b1, 1'b0);

        // Reset while full, then resume
        cyc(1'b1, 32'h0020_81B3, 1'b0, 1'b0);
        cyc(1'b1, 32'h4020_81B3, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 32'h0050_0093, 1'b1, 1'b0);
        cyc(1'b1, 32'h0020_81B3, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 63) == 0));
            in_pc = $urandom;
        end
        rst_n = 1'b1;
        repeat (4) cyc(1'b0, 32'd0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
